comp_bit_packer: RTL
====================

Name: comp_bit_packer

Overview:
- Sequential successor to the stage-3 word merger. Accepts up to two variable-length compressed codes per cycle and ORs them LSB-first into a parametrised accumulator at the current fill offset.
- Emits fixed-width packed words through a valid/ready handshake.
- Supports an explicit flush that drains the residual as a zero-padded final word.
- Sits between the compressor's code-generation stages and the compressed-line write buffer.

Parameters:
- I_WIDTH1, 68, max bit width of first code.
- I_WIDTH2, 34, max bit width of second code.
- OUT_WIDTH, 64, packed output word width.
- ACC_WIDTH, 256, accumulator width. Must be >= OUT_WIDTH + I_WIDTH1 + I_WIDTH2; elaboration error otherwise.
- FILL_W, $clog2(ACC_WIDTH+1), width of fill counter (derived, not overridable).

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_reset  input  1  synchronous reset, active-high.
- i_valid  input  1  input beat valid.
- o_ready  output  1  block can accept a beat.
- i_first_word  input  I_WIDTH1  first code, LSB-aligned.
- i_first_len  input  $clog2(I_WIDTH1+1)  valid bits in first code (0..I_WIDTH1).
- i_second_word  input  I_WIDTH2  second code, LSB-aligned.
- i_second_len  input  $clog2(I_WIDTH2+1)  valid bits in second code.
- i_flush  input  1  end-of-line marker, qualified by i_valid && o_ready.
- o_valid  output  1  o_word valid.
- i_ready  input  1  downstream accepts o_word.
- o_word  output  OUT_WIDTH  packed word = acc[OUT_WIDTH-1:0].
- o_last  output  1  final word of a flush.
- o_flush_done  output  1  one-cycle pulse when flush drain completes.
- o_fill  output  FILL_W  current valid bits in accumulator.

Behaviour:
- Reset (synchronous, i_reset=1 at edge):
  - acc=0, fill=0, state=RUN.
  - o_valid=0, o_last=0, o_flush_done=0, o_fill=0.
  - o_ready=1 from the first cycle after reset deassertion.
  - Reset mid-flush discards residual; no o_last or o_flush_done is produced.
- Length rules:
  - len greater than its width saturates to the width.
  - Bits at or above len are masked to 0 before merge.
  - Merge places the first code at bit offset f and the second at f+len1, then ORs into acc.
  - len=0 contributes nothing.
- Input acceptance: beat accepted when i_valid && o_ready.
  - o_ready = (state==RUN) && (fill <= ACC_WIDTH - I_WIDTH1 - I_WIDTH2).
  - o_ready is combinational from registered state only; no i_valid→o_ready path.
- Output:
  - RUN: o_valid = (fill >= OUT_WIDTH).
  - FLUSH: o_valid = (fill > 0).
  - o_last = (state==FLUSH) && (fill <= OUT_WIDTH).
  - On o_valid && i_ready: acc >>= OUT_WIDTH (zero fill), fill -= min(fill, OUT_WIDTH).
  - o_word must hold stable while o_valid && !i_ready.
  - Zero-padding of the final word is guaranteed by the shifted-in zeros.
- Simultaneous output handshake and input accept in the same cycle:
  - Shift first, then merge.
  - New codes land at offset f = fill - OUT_WIDTH.
  - fill_next = fill - OUT_WIDTH + len1 + len2.
- States:
  - RUN → FLUSH when an accepted beat has i_flush=1. That beat's codes are merged first.
  - FLUSH → RUN when fill_next == 0, either via the o_last handshake or because fill was already 0. The transition asserts o_flush_done for exactly one cycle.
  - With fill_next == 0 at flush acceptance, the block enters FLUSH for one cycle, emits no word, pulses o_flush_done, and returns to RUN.
- Throughput: one beat per cycle while downstream keeps up and average code length per beat <= OUT_WIDTH.

Optional Feature:
- Macro: COMP_BIT_PACKER_STATS_EN.
- Defined:
  - Adds output o_bits_in (32b), saturating count of accepted code bits (len1+len2).
  - Adds output o_words_out (32b), saturating count of output handshakes.
  - Both cleared by i_reset.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package comp_pack_pkg holds:
  - state enum {RUN, FLUSH}.
  - Function len_sat(len, width).
  - Function mask_bits(word, len).
  - Elaboration-check localparams.
- Sub-module pack_merge (combinational):
  - Inputs: acc, offset, masked codes, lengths.
  - Output: merged acc.
  - Reused for the shift-then-merge path.

Test Plan:
- Reset: assert i_reset 2 cycles during traffic → o_valid=0, o_fill=0, o_ready=1 next cycle, no o_flush_done.
- Pair merge: first=0x5 len 3, second=0x3 len 2 → o_fill=5, acc[4:0]=5'b11101, o_valid=0. first=0xFF len 4 → only 0xF merged (masking).
- Word crossing: two beats of (all-ones len 34, len2=0) → fill=68, o_valid=1, o_word=64'hFFFF_FFFF_FFFF_FFFF. Handshake plus simultaneous beat (0x1 len 1) → fill=5, acc[4:0]=5'b11111.
- Backpressure: i_ready=0, beats of 34+34 → o_ready drops once fill > 154 (at fill=204). o_word stable throughout. Release i_ready → words drain in order, o_ready returns.
- Flush with fill=10: o_valid=1, o_last=1, o_word[63:10]=0. Handshake → o_flush_done pulse, state RUN. Flush with fill=0 → o_flush_done next cycle, no o_valid.
- Length saturation: i_first_len=100 (I_WIDTH1=68) → fill advances by 68. With COMP_BIT_PACKER_STATS_EN, o_bits_in=68.

Source files
------------

// File: rtl/comp_pack_pkg.sv
// Shared types and helpers for the compressed-code bit packer.
//   state_e       : packer state (RUN accepts beats, FLUSH drains the residual)
//   len_sat       : clamp a code length to the code's maximum width
//   mask_bits     : zero every bit at or above a given length
//   acc_width_ok  : elaboration check that the accumulator can absorb a full beat
//                   while still holding one output word
package comp_pack_pkg;

  typedef enum logic [0:0] {RUN, FLUSH} state_e;

  // Widest code the masking helper handles; codes are zero-extended to this.
  localparam int unsigned MAX_CODE_W = 128;

  localparam int unsigned DEF_I_WIDTH1  = 68;
  localparam int unsigned DEF_I_WIDTH2  = 34;
  localparam int unsigned DEF_OUT_WIDTH = 64;
  localparam int unsigned DEF_ACC_WIDTH = 256;

  function automatic int unsigned len_sat(input int unsigned len, input int unsigned width);
    return (len > width) ? width : len;
  endfunction

  function automatic logic [MAX_CODE_W-1:0] mask_bits(input logic [MAX_CODE_W-1:0] word,
                                                      input int unsigned len);
    logic [MAX_CODE_W-1:0] one;
    one = {{(MAX_CODE_W-1){1'b0}}, 1'b1};
    // len == MAX_CODE_W shifts the one out, so the subtraction yields all ones.
    return word & ((one << len) - one);
  endfunction

  function automatic bit acc_width_ok(input int unsigned acc_w, input int unsigned out_w,
                                      input int unsigned w1, input int unsigned w2);
    return acc_w >= out_w + w1 + w2;
  endfunction

endpackage

// File: rtl/pack_merge.sv
// Combinational merge of two masked codes into the accumulator.
//   acc          : accumulator contents (bits at and above offset are zero)
//   offset       : bit position where the first code lands
//   first_code   : masked first code, LSB-aligned
//   first_len    : saturated length of the first code; second code starts after it
//   second_code  : masked second code, LSB-aligned
//   merged       : acc with both codes ORed in
module pack_merge
  import comp_pack_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int unsigned I_WIDTH1  = DEF_I_WIDTH1,
  parameter int unsigned I_WIDTH2  = DEF_I_WIDTH2,
  parameter int unsigned FILL_W    = $clog2(ACC_WIDTH + 1),
  parameter int unsigned L1_W      = $clog2(I_WIDTH1 + 1)
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic [FILL_W-1:0]    offset,
  input  logic [I_WIDTH1-1:0]  first_code,
  input  logic [L1_W-1:0]      first_len,
  input  logic [I_WIDTH2-1:0]  second_code,
  output logic [ACC_WIDTH-1:0] merged
);

  logic [ACC_WIDTH-1:0] first_ext;
  logic [ACC_WIDTH-1:0] second_ext;
  logic [FILL_W:0]      second_off;

  assign first_ext  = ACC_WIDTH'(first_code);
  assign second_ext = ACC_WIDTH'(second_code);
  assign second_off = {1'b0, offset} + (FILL_W+1)'(first_len);
  assign merged     = acc | (first_ext << offset) | (second_ext << second_off);

endmodule

// File: rtl/comp_bit_packer.sv
// Packs up to two variable-length codes per beat LSB-first into fixed-width words.
// Optional build macro COMP_BIT_PACKER_STATS_EN adds saturating bit/word counters.
//   i_clk, i_reset            : clock, synchronous active-high reset
//   i_valid / o_ready         : input beat handshake
//   i_first_word/_len         : first code and its length (saturated to I_WIDTH1)
//   i_second_word/_len        : second code and its length (saturated to I_WIDTH2)
//   i_flush                   : end of line; drain residual as zero-padded final word
//   o_valid / i_ready         : output word handshake
//   o_word, o_last            : packed word, final word of a flush
//   o_flush_done              : one-cycle pulse once a flush has fully drained
//   o_fill                    : valid bits held in the accumulator
//   o_bits_in, o_words_out    : (stats build only) accepted code bits, output words
module comp_bit_packer
  import comp_pack_pkg::*;
#(
  parameter  int unsigned I_WIDTH1  = DEF_I_WIDTH1,
  parameter  int unsigned I_WIDTH2  = DEF_I_WIDTH2,
  parameter  int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
  parameter  int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
  localparam int unsigned FILL_W    = $clog2(ACC_WIDTH + 1),
  localparam int unsigned L1_W      = $clog2(I_WIDTH1 + 1),
  localparam int unsigned L2_W      = $clog2(I_WIDTH2 + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [I_WIDTH1-1:0]  i_first_word,
  input  logic [L1_W-1:0]      i_first_len,
  input  logic [I_WIDTH2-1:0]  i_second_word,
  input  logic [L2_W-1:0]      i_second_len,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OUT_WIDTH-1:0] o_word,
  output logic                 o_last,
  output logic                 o_flush_done,
  output logic [FILL_W-1:0]    o_fill
`ifdef COMP_BIT_PACKER_STATS_EN
  ,
  output logic [31:0]          o_bits_in,
  output logic [31:0]          o_words_out
`endif
);

  if (!acc_width_ok(ACC_WIDTH, OUT_WIDTH, I_WIDTH1, I_WIDTH2)) begin : g_bad_acc
    $error("ACC_WIDTH must be >= OUT_WIDTH + I_WIDTH1 + I_WIDTH2");
  end
  if (I_WIDTH1 > MAX_CODE_W || I_WIDTH2 > MAX_CODE_W) begin : g_bad_code
    $error("code widths exceed MAX_CODE_W");
  end

  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d, base_acc, merged_acc;
  logic [FILL_W-1:0]    fill_q, fill_d, base_fill;
  logic                 flush_done_q;
  logic                 in_fire, out_fire;
  logic [L1_W-1:0]      len1_sat;
  logic [L2_W-1:0]      len2_sat;
  logic [I_WIDTH1-1:0]  code1;
  logic [I_WIDTH2-1:0]  code2;

  assign o_ready = (state_q == RUN) &&
                   (fill_q <= FILL_W'(ACC_WIDTH - I_WIDTH1 - I_WIDTH2));
  assign o_valid = (state_q == RUN) ? (fill_q >= FILL_W'(OUT_WIDTH)) : (fill_q != '0);
  assign o_last  = (state_q == FLUSH) && (fill_q <= FILL_W'(OUT_WIDTH));
  assign o_word  = acc_q[OUT_WIDTH-1:0];
  assign o_fill  = fill_q;
  assign o_flush_done = flush_done_q;

  assign in_fire  = i_valid && o_ready;
  assign out_fire = o_valid && i_ready;

  assign len1_sat = L1_W'(len_sat(32'(i_first_len), I_WIDTH1));
  assign len2_sat = L2_W'(len_sat(32'(i_second_len), I_WIDTH2));
  assign code1    = I_WIDTH1'(mask_bits(MAX_CODE_W'(i_first_word), 32'(len1_sat)));
  assign code2    = I_WIDTH2'(mask_bits(MAX_CODE_W'(i_second_word), 32'(len2_sat)));

  // Retire the outgoing word first so new codes land just above what remains.
  assign base_acc  = out_fire ? (acc_q >> OUT_WIDTH) : acc_q;
  assign base_fill = !out_fire ? fill_q :
                     (fill_q > FILL_W'(OUT_WIDTH)) ? fill_q - FILL_W'(OUT_WIDTH) : '0;

  pack_merge #(
    .ACC_WIDTH (ACC_WIDTH),
    .I_WIDTH1  (I_WIDTH1),
    .I_WIDTH2  (I_WIDTH2),
    .FILL_W    (FILL_W),
    .L1_W      (L1_W)
  ) u_merge (
    .acc         (base_acc),
    .offset      (base_fill),
    .first_code  (code1),
    .first_len   (len1_sat),
    .second_code (code2),
    .merged      (merged_acc)
  );

  always_comb begin
    acc_d  = base_acc;
    fill_d = base_fill;
    if (in_fire) begin
      acc_d  = merged_acc;
      fill_d = base_fill + FILL_W'(len1_sat) + FILL_W'(len2_sat);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= RUN;
      acc_q        <= '0;
      fill_q       <= '0;
      flush_done_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_done_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (in_fire && i_flush) state_q <= FLUSH;
        end
        FLUSH: begin
          if (fill_d == '0) begin
            state_q      <= RUN;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef COMP_BIT_PACKER_STATS_EN
  logic [31:0] bits_in_q, words_out_q;
  logic [32:0] bits_sum;

  assign bits_sum    = {1'b0, bits_in_q} + 33'(len1_sat) + 33'(len2_sat);
  assign o_bits_in   = bits_in_q;
  assign o_words_out = words_out_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bits_in_q   <= '0;
      words_out_q <= '0;
    end else begin
      if (in_fire) bits_in_q <= bits_sum[32] ? '1 : bits_sum[31:0];
      if (out_fire && (words_out_q != '1)) words_out_q <= words_out_q + 32'd1;
    end
  end
`endif

endmodule
